// File: rtl/branch_predictor_if.sv
// Fetch-lookup and branch-resolve bundle between the pipeline and the branch predictor.
// Latency: none of its own; it only carries signals.
// Backpressure: none. The resolving stage presents each branch for exactly one cycle.
//
// Signals, as seen by the predictor (slave modport):
//   in : clear, pc_in, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target
//   out: pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic            clear;
    logic [XLEN-1:0] pc_in;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    // Pipeline side: it drives lookups and resolved branches.
    modport master (
        output clear, pc_in, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

    // Predictor side.
    modport slave (
        input  clear, pc_in, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped BTB with a saturating direction counter per entry.
// Latency: lookup and mispredict/redirect are combinational; a table update is visible the cycle after it is presented.
// Backpressure: none. Each resolved branch is accepted in its single upd_valid cycle.
//
// Ports: clk (all state on the rising edge); reset (asynchronous, active low);
//        bp (branch_predictor_if.slave): fetch lookup, branch resolution, mispredict redirect, statistics.
// Optional feature: define BP_STATS_EN to build the saturating stat_branches and stat_mispredicts counters.
//                   Without it, both outputs are tied to zero.
module branch_predictor #(
    parameter int XLEN         = 32,
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int TAG_BITS     = 8
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int IDX = $clog2(ENTRIES);

    typedef logic [IDX-1:0]          idx_t;
    typedef logic [TAG_BITS-1:0]     tag_t;
    typedef logic [COUNTER_BITS-1:0] ctr_t;
    typedef logic [XLEN-1:0]         addr_t;

    // Weakly not-taken is MSB 0 with the rest 1. Weakly taken is MSB 1 with the rest 0.
    localparam ctr_t CTR_WNT = ctr_t'((1 << (COUNTER_BITS - 1)) - 1);
    localparam ctr_t CTR_WT  = ctr_t'(1 << (COUNTER_BITS - 1));
    localparam ctr_t CTR_MAX = {COUNTER_BITS{1'b1}};

    // Packed tables, so that reset and clear each write the whole array in a single assignment.
    logic [ENTRIES-1:0]                 valid_q;
    logic [ENTRIES-1:0][TAG_BITS-1:0]   tag_q;
    logic [ENTRIES-1:0][XLEN-1:0]       tgt_q;
    logic [ENTRIES-1:0][COUNTER_BITS-1:0] ctr_q;

    // ---------------- Lookup (reads the registered table, with no bypass) ----------------
    idx_t lk_idx;
    tag_t lk_tag;
    logic lk_hit;

    assign lk_idx = bp.pc_in[IDX+1:2];
    assign lk_tag = bp.pc_in[IDX+TAG_BITS+1:IDX+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bp.pred_taken  = lk_hit && ctr_q[lk_idx][COUNTER_BITS-1];
    assign bp.pred_target = bp.pred_taken ? tgt_q[lk_idx] : bp.pc_in + addr_t'(4);

    // ---------------- Resolve: mispredict and redirect ----------------
    assign bp.mispredict  = bp.upd_valid &&
                            ((bp.upd_pred_taken != bp.upd_taken) ||
                             (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + addr_t'(4);

    // ---------------- Update: next state of the one indexed entry ----------------
    idx_t  up_idx;
    tag_t  up_tag;
    logic  up_hit;
    logic  wr_en;
    tag_t  tag_d;
    addr_t tgt_d;
    ctr_t  ctr_d;

    assign up_idx = bp.upd_pc[IDX+1:2];
    assign up_tag = bp.upd_pc[IDX+TAG_BITS+1:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en = 1'b0;
        tag_d = tag_q[up_idx];
        tgt_d = tgt_q[up_idx];
        ctr_d = ctr_q[up_idx];
        if (bp.upd_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (bp.upd_taken) begin
                    ctr_d = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + ctr_t'(1);
                    tgt_d = bp.upd_target;
                end else begin
                    ctr_d = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - ctr_t'(1);
                end
            end else if (bp.upd_taken) begin
                // Allocate only on a taken branch. A not-taken miss leaves any occupant of the slot in place.
                wr_en = 1'b1;
                tag_d = up_tag;
                tgt_d = bp.upd_target;
                ctr_d = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= {ENTRIES{CTR_WNT}};
        end else if (bp.clear) begin
            // clear takes priority over an update in the same cycle. Tags and targets go stale but are unreachable.
            valid_q <= '0;
            ctr_q   <= {ENTRIES{CTR_WNT}};
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= tag_d;
            tgt_q[up_idx]   <= tgt_d;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

    // ---------------- Statistics ----------------
`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (bp.upd_valid && (stat_br_q != 32'hFFFF_FFFF)) stat_br_d = stat_br_q + 32'd1;
        if (bp.mispredict && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_d = stat_mp_q + 32'd1;
    end

    // Only reset clears the counters. clear leaves them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif
endmodule
